// File: rtl/arith_pkg.sv
// Shared definitions for the multi-cycle arithmetic blocks.
// Holds the serial FSM state type and the iteration-counter width helper.
package arith_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } serial_add_state_t;

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice.
// Built from full-adder cells: XOR-of-three sum, majority carry.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle serial adder: a + b + carryin, DIGIT bits per clock.
// start/done handshake; sum/carry hold the last completed result.
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    serial_add_state_t state, nxt;

    logic [WIDTH-1:0] ra, rb, rr, res_nxt;
    logic             rc;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] ds;
    logic             dcout;
    logic             last;

    digit_adder #(.DIGIT(DIGIT)) u_slice (
        .a    (ra[DIGIT-1:0]),
        .b    (rb[DIGIT-1:0]),
        .cin  (rc),
        .s    (ds),
        .cout (dcout)
    );

    // Result fills from the MSB end so the first digit lands at bit 0 after N shifts.
    if (DIGIT == WIDTH) begin : g_res_full
        assign res_nxt = ds;
    end else begin : g_res_shift
        assign res_nxt = {ds, rr[WIDTH-1:DIGIT]};
    end

    assign last = (cnt == CW'(N - 1));
    assign busy = (state == RUN);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (last)  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ra    <= '0;
            rb    <= '0;
            rr    <= '0;
            rc    <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        rc  <= carryin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    ra  <= ra >> DIGIT;
                    rb  <= rb >> DIGIT;
                    rr  <= res_nxt;
                    rc  <= dcout;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        sum   <= res_nxt;
                        carry <= dcout;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four instances (DIGIT = 1, 2, 4, 8 at WIDTH = 8)
// checked against directed expectations and a cycle-level arithmetic model.
module tb_serial_adder;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      start_v, cin_v, busy_v, done_v, carry_v;
    logic [3:0][7:0] a_v, b_v, sum_v;
    logic            mon_en = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int D  = 1 << g;
        localparam int NN = 8 / D;

        serial_adder #(.WIDTH(8), .DIGIT(D)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start_v[g]),
            .a       (a_v[g]),
            .b       (b_v[g]),
            .carryin (cin_v[g]),
            .busy    (busy_v[g]),
            .done    (done_v[g]),
            .sum     (sum_v[g]),
            .carry   (carry_v[g])
        );

        // Reference: remaining busy cycles and the full-width sum of the accepted operands.
        int         rem;
        logic [8:0] pend, exp_res;
        logic       exp_done;

        always @(posedge clk) begin
            if (rst) begin
                rem      <= 0;
                exp_res  <= '0;
                exp_done <= 1'b0;
            end else begin
                exp_done <= 1'b0;
                if (rem == 0) begin
                    if (start_v[g]) begin
                        rem  <= NN;
                        pend <= {1'b0, a_v[g]} + {1'b0, b_v[g]} + {8'b0, cin_v[g]};
                    end
                end else begin
                    rem <= rem - 1;
                    if (rem == 1) begin
                        exp_done <= 1'b1;
                        exp_res  <= pend;
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (mon_en) begin
                chk($sformatf("d%0d_busy", D), 32'(busy_v[g]), 32'(rem != 0));
                chk($sformatf("d%0d_done", D), 32'(done_v[g]), 32'(exp_done));
                chk($sformatf("d%0d_res", D), 32'({carry_v[g], sum_v[g]}), 32'(exp_res));
            end
        end
    end

    // Issue one start in the current cycle; return at the negedge where done is seen.
    task automatic op(input int k, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      output int lat, output int bcnt);
        start_v[k] = 1'b1;
        a_v[k]     = av;
        b_v[k]     = bv;
        cin_v[k]   = cv;
        @(negedge clk);
        start_v[k] = 1'b0;
        a_v[k]     = 8'($urandom);
        b_v[k]     = 8'($urandom);
        cin_v[k]   = 1'($urandom);
        lat  = 1;
        bcnt = 0;
        while (!done_v[k] && lat < 40) begin
            bcnt += int'(busy_v[k]);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op_chk(input int k, input logic [7:0] av, input logic [7:0] bv, input logic cv);
        int lat, bcnt;
        logic [8:0] e;
        e = {1'b0, av} + {1'b0, bv} + {8'b0, cv};
        op(k, av, bv, cv, lat, bcnt);
        chk($sformatf("rnd_lat_d%0d", 1 << k), 32'(lat), 32'((8 >> k) + 1));
        chk($sformatf("rnd_res_d%0d", 1 << k), 32'({carry_v[k], sum_v[k]}), 32'(e));
    endtask

    initial begin
        int lat, bcnt;
        rst     = 1'b1;
        start_v = '0;
        cin_v   = '0;
        a_v     = '0;
        b_v     = '0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_busy", 32'(busy_v[k]), 32'd0);
            chk("rst_done", 32'(done_v[k]), 32'd0);
            chk("rst_res", 32'({carry_v[k], sum_v[k]}), 32'd0);
        end
        @(negedge clk);

        // DIGIT=1: 0xFF + 0x01 wraps to zero with carry out.
        op(0, 8'hFF, 8'h01, 1'b0, lat, bcnt);
        chk("t1_lat", 32'(lat), 32'd9);
        chk("t1_busy_cycles", 32'(bcnt), 32'd8);
        chk("t1_sum", 32'(sum_v[0]), 32'h00);
        chk("t1_carry", 32'(carry_v[0]), 32'd1);
        @(negedge clk);

        // DIGIT=4 with carry-in.
        op(2, 8'h3C, 8'h5A, 1'b1, lat, bcnt);
        chk("t2_lat", 32'(lat), 32'd3);
        chk("t2_sum", 32'(sum_v[2]), 32'h97);
        chk("t2_carry", 32'(carry_v[2]), 32'd0);
        @(negedge clk);

        // DIGIT=2: a second start in cycle 2 must be ignored.
        start_v[1] = 1'b1; a_v[1] = 8'h10; b_v[1] = 8'h20; cin_v[1] = 1'b0;
        @(negedge clk);
        start_v[1] = 1'b0;
        @(negedge clk);
        start_v[1] = 1'b1; a_v[1] = 8'hFF; b_v[1] = 8'hFF;
        @(negedge clk);
        start_v[1] = 1'b0;
        lat = 3;
        while (!done_v[1] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("t3_lat", 32'(lat), 32'd5);
        chk("t3_sum", 32'(sum_v[1]), 32'h30);
        chk("t3_carry", 32'(carry_v[1]), 32'd0);

        // Back-to-back: start in the done cycle.
        op(1, 8'h80, 8'h80, 1'b0, lat, bcnt);
        chk("t4_lat", 32'(lat), 32'd5);
        chk("t4_busy_cycles", 32'(bcnt), 32'd4);
        chk("t4_sum", 32'(sum_v[1]), 32'h00);
        chk("t4_carry", 32'(carry_v[1]), 32'd1);
        @(negedge clk);

        // Reset in cycle 3 of a DIGIT=1 run aborts it.
        start_v[0] = 1'b1; a_v[0] = 8'hAA; b_v[0] = 8'h56; cin_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", 32'(busy_v[0]), 32'd0);
        chk("t5_done", 32'(done_v[0]), 32'd0);
        chk("t5_sum", 32'(sum_v[0]), 32'd0);
        chk("t5_carry", 32'(carry_v[0]), 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("t5_no_done", 32'(done_v[0]), 32'd0);
            @(negedge clk);
        end
        op_chk(0, 8'h7F, 8'h01, 1'b1);
        @(negedge clk);

        // Random regression with random gaps, including back-to-back starts.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 1000; i++) begin
                op_chk(k, 8'($urandom), 8'($urandom), 1'($urandom));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end

        repeat (12) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
